// File: rtl/sram_like_responder_pkg.sv
// Shared encodings for the SRAM-like responder: FSM states and access sizes.
package sram_like_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/sram_like_responder_if.sv
// Cache-side request/response bus; master is the requester, slave the responder.
interface sram_like_responder_if;

    logic        cache_data_req;
    logic        cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr;
    logic [31:0] cache_data_wdata;
    logic [31:0] cache_data_rdata;
    logic        cache_data_addr_ok;
    logic        cache_data_data_ok;

    modport master (
        output cache_data_req,
        output cache_data_wr,
        output cache_data_size,
        output cache_data_addr,
        output cache_data_wdata,
        input  cache_data_rdata,
        input  cache_data_addr_ok,
        input  cache_data_data_ok
    );

    modport slave (
        input  cache_data_req,
        input  cache_data_wr,
        input  cache_data_size,
        input  cache_data_addr,
        input  cache_data_wdata,
        output cache_data_rdata,
        output cache_data_addr_ok,
        output cache_data_data_ok
    );

endinterface

// File: rtl/sram_like_mem_array.sv
// Word-organised backing store: asynchronous read, synchronous byte-enabled write.
module sram_like_mem_array #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    // No reset: contents are undefined after power-up and survive rst.
    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_like_responder.sv
// Single-outstanding SRAM-like responder with fixed LATENCY from address accept to data_ok.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_like_responder_if.slave bus,
    output logic                 busy,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  busy_q;
    logic [31:0]           rd_count_q;
    logic [31:0]           wr_count_q;

    logic        in_resp;
    logic        mem_we;
    logic [3:0]  byte_en;
    logic [31:0] mem_rdata;
    logic        unused_addr_hi;

    // Bits above the word index are ignored, so the address wraps over the array.
    assign unused_addr_hi = ^bus.cache_data_addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cache_data_req) begin
                        wr_q    <= bus.cache_data_wr;
                        size_q  <= bus.cache_data_size;
                        addr_q  <= bus.cache_data_addr[ADDR_WIDTH+1:0];
                        wdata_q <= bus.cache_data_wdata;
                        busy_q  <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntWidth'(LATENCY - 2);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (wr_q) begin
                        wr_count_q <= wr_count_q + 32'd1;
                    end else begin
                        rd_count_q <= rd_count_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            SZ_BYTE:       byte_en = 4'b0001 << addr_q[1:0];
            SZ_HALF:       byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            SZ_WORD, 2'd3: byte_en = 4'b1111;
            default:       byte_en = 4'b0000;
        endcase
    end

    // Gating with rst makes a reset during RESP abort both the write and data_ok.
    assign in_resp = rst && (state_q == StResp);
    assign mem_we  = in_resp && wr_q;

    sram_like_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .be   (byte_en),
        .addr (addr_q[ADDR_WIDTH+1:2]),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    assign bus.cache_data_addr_ok = rst && (state_q == StIdle) && bus.cache_data_req;
    assign bus.cache_data_data_ok = in_resp;
    assign bus.cache_data_rdata   = (in_resp && !wr_q) ? mem_rdata : 32'd0;

    assign busy     = busy_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench: three responders (LATENCY 2, 3, 1) checked against a byte-level memory model.
module tb_sram_like_responder;

    localparam int unsigned MemBytes = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        aok_a [3];
    logic        dok_a [3];
    logic [31:0] rd_a  [3];
    logic        busy_a[3];
    logic [31:0] rdc_a [3];
    logic [31:0] wrc_a [3];

    logic        addr_ok_m, data_ok_m, busy_m;
    logic [31:0] rdata_m, rdc_m, wrc_m;

    sram_like_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].cache_data_req   = req && (sel == g);
        assign bus[g].cache_data_wr    = wr;
        assign bus[g].cache_data_size  = size;
        assign bus[g].cache_data_addr  = addr;
        assign bus[g].cache_data_wdata = wdata;
        assign aok_a[g] = bus[g].cache_data_addr_ok;
        assign dok_a[g] = bus[g].cache_data_data_ok;
        assign rd_a[g]  = bus[g].cache_data_rdata;

        sram_like_responder #(
            .ADDR_WIDTH(12),
            .LATENCY   ((g == 0) ? 2 : (g == 1) ? 3 : 1)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus[g]),
            .busy    (busy_a[g]),
            .rd_count(rdc_a[g]),
            .wr_count(wrc_a[g])
        );
    end

    always_comb begin
        addr_ok_m = aok_a[sel];
        data_ok_m = dok_a[sel];
        rdata_m   = rd_a[sel];
        busy_m    = busy_a[sel];
        rdc_m     = rdc_a[sel];
        wrc_m     = wrc_a[sel];
    end

    int          lat_of [3] = '{2, 3, 1};
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  ref_mem [int unsigned];
    int unsigned rd_ref [3];
    int unsigned wr_ref [3];
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int unsigned key(input int d, input logic [31:0] a);
        return 32'(d) * MemBytes + (a & (MemBytes - 1));
    endfunction

    // One complete transaction on responder d; entered and left just after a falling edge.
    task automatic do_txn(input int d, input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        int          l = lat_of[d];
        int          n;
        logic [31:0] exp_rd = '0;
        logic [31:0] base, ba;
        bit          known = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int unsigned k = key(d, (a & 32'hFFFF_FFFC) + 32'(i));
            if (ref_mem.exists(k)) exp_rd[8*i +: 8] = ref_mem[k];
            else known = 1'b0;
        end
        sel = d; req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
        #1;
        chk("addr_ok_in_req_cycle", 32'(addr_ok_m), 32'd1);
        chk("busy_before_accept", 32'(busy_m), 32'd0);
        @(negedge clk);
        // Scramble inputs after acceptance; the latched transaction must be unaffected.
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom);
        addr = $urandom; wdata = $urandom;
        for (int k = 1; k <= l; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk("busy_outstanding", 32'(busy_m), 32'd1);
            chk("addr_ok_low_while_busy", 32'(addr_ok_m), 32'd0);
            chk("data_ok_timing", 32'(data_ok_m), (k == l) ? 32'd1 : 32'd0);
            if (k == l) begin
                last_rdata = rdata_m;
                if (!w && known) chk("read_data", rdata_m, exp_rd);
                chk("rd_count_in_resp", rdc_m, rd_ref[d]);
                chk("wr_count_in_resp", wrc_m, wr_ref[d]);
            end else begin
                chk("rdata_zero_outside_resp", rdata_m, 32'd0);
            end
        end
        if (w) begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            base = a & ~32'(n - 1);
            for (int i = 0; i < n; i++) begin
                ba = base + 32'(i);
                ref_mem[key(d, ba)] = wd[8*ba[1:0] +: 8];
            end
            wr_ref[d]++;
        end else begin
            rd_ref[d]++;
        end
        @(negedge clk);
        #1;
        chk("data_ok_single_pulse", 32'(data_ok_m), 32'd0);
        chk("busy_after_resp", 32'(busy_m), 32'd0);
        chk("rd_count_after", rdc_m, rd_ref[d]);
        chk("wr_count_after", wrc_m, wr_ref[d]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int first_acc, second_acc, first_dok, second_dok;
        rst = 1'b0; req = 1'b1; sel = 0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        for (int d = 0; d < 3; d++) begin rd_ref[d] = 0; wr_ref[d] = 0; end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk("reset_addr_ok", 32'(addr_ok_m), 32'd0);
            chk("reset_data_ok", 32'(data_ok_m), 32'd0);
            chk("reset_rdata", rdata_m, 32'd0);
            chk("reset_busy", 32'(busy_m), 32'd0);
            chk("reset_rd_count", rdc_m, 32'd0);
            chk("reset_wr_count", wrc_m, 32'd0);
        end
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        #1;

        // Word write then read, LATENCY=2.
        do_txn(0, 1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        do_txn(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
        chk("word_rw_data", last_rdata, 32'hDEAD_BEEF);

        // Byte and halfword merges into an existing word.
        do_txn(0, 1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344);
        do_txn(0, 1'b1, 2'd0, 32'h0000_0023, 32'hAA00_0000);
        do_txn(0, 1'b1, 2'd1, 32'h0000_0020, 32'h0000_5566);
        do_txn(0, 1'b0, 2'd2, 32'h0000_0020, 32'h0);
        chk("byte_half_merge", last_rdata, 32'hAA22_5566);

        // Size 3 read at an unaligned address returns the whole word.
        do_txn(0, 1'b1, 2'd2, 32'h0000_0040, 32'h0BAD_F00D);
        do_txn(0, 1'b0, 2'd3, 32'h0000_0042, 32'h0);
        chk("size3_full_word", last_rdata, 32'h0BAD_F00D);

        // Reset while a write waits: no write, no data_ok, counters cleared.
        do_txn(0, 1'b1, 2'd2, 32'h0000_0040, 32'h0000_0000);
        sel = 0; req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'h1234_5678;
        #1;
        chk("abort_accept", 32'(addr_ok_m), 32'd1);
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        #1;
        chk("abort_data_ok_in_reset", 32'(data_ok_m), 32'd0);
        chk("abort_rdata_in_reset", rdata_m, 32'd0);
        chk("abort_addr_ok_in_reset", 32'(addr_ok_m), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_no_data_ok", 32'(data_ok_m), 32'd0);
        chk("abort_busy", 32'(busy_m), 32'd0);
        for (int d = 0; d < 3; d++) begin rd_ref[d] = 0; wr_ref[d] = 0; end
        chk("abort_wr_count", wrc_m, 32'd0);
        do_txn(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
        chk("abort_old_data", last_rdata, 32'h0);
        chk("abort_rd_count", rdc_m, 32'd1);
        chk("abort_wr_count_after_read", wrc_m, 32'd0);

        // Back-to-back writes with req held, LATENCY=3.
        first_acc = -1; second_acc = -1; first_dok = -1; second_dok = -1;
        sel = 1; req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h100; wdata = 32'h1111_AAAA;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("b2b_no_addr_ok_while_busy", 32'(addr_ok_m && busy_m), 32'd0);
            if (addr_ok_m) begin
                if (first_acc < 0) first_acc = c;
                else if (second_acc < 0) second_acc = c;
            end
            if (data_ok_m) begin
                if (first_dok < 0) first_dok = c;
                else if (second_dok < 0) second_dok = c;
            end
            @(negedge clk);
            if (second_acc >= 0) req = 1'b0;
            else if (first_acc >= 0) begin addr = 32'h104; wdata = 32'h2222_BBBB; end
        end
        #1;
        chk("b2b_first_accept", 32'(first_acc), 32'd0);
        chk("b2b_first_data_ok", 32'(first_dok), 32'd3);
        chk("b2b_second_accept", 32'(second_acc), 32'(first_dok + 1));
        chk("b2b_second_data_ok", 32'(second_dok), 32'(second_acc + 3));
        chk("b2b_wr_count", wrc_m, 32'd2);
        for (int i = 0; i < 4; i++) begin
            ref_mem[key(1, 32'h100 + 32'(i))] = 8'(32'h1111_AAAA >> (8 * i));
            ref_mem[key(1, 32'h104 + 32'(i))] = 8'(32'h2222_BBBB >> (8 * i));
        end
        wr_ref[1] = 2;
        do_txn(1, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        chk("b2b_first_data", last_rdata, 32'h1111_AAAA);
        do_txn(1, 1'b0, 2'd2, 32'h0000_0104, 32'h0);
        chk("b2b_second_data", last_rdata, 32'h2222_BBBB);

        // Address wrap, LATENCY=1.
        do_txn(2, 1'b1, 2'd2, 32'h0000_4000, 32'h0000_CAFE);
        do_txn(2, 1'b0, 2'd2, 32'h0000_0000, 32'h0);
        chk("wrap_data", last_rdata, 32'h0000_CAFE);

        // Randomized traffic on every responder.
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 25; t++) begin
                do_txn(d, 1'($urandom), 2'($urandom),
                       ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63)), $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
